// File: rtl/mini16_s2m_collector_pkg.sv
// Shared definitions for the mini16 slave-to-master collector.
//   state_e    : collector FSM states
//   clog2_min1 : index width for a PE count, never less than one bit
//   word_addr / word_data : split a FIFO word {addr, data} into its fields
package mini16_s2m_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StWrite
  } state_e;

  // Widest FIFO word the slicing helpers handle (WIDTH_D + DEPTH_V_F).
  localparam int unsigned MaxWordW = 64;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Address lives above the data field.
  function automatic logic [MaxWordW-1:0] word_addr(input logic [MaxWordW-1:0] word,
                                                    input int unsigned width_d);
    return word >> width_d;
  endfunction

  function automatic logic [MaxWordW-1:0] word_data(input logic [MaxWordW-1:0] word,
                                                    input int unsigned width_d);
    return word & ((64'd1 << width_d) - 64'd1);
  endfunction

endpackage

// File: rtl/mini16_s2m_collector_if.sv
// Bus bundle between the collector, the PE slave-to-master FIFOs and the master write port.
//   fifo_req_r  : one-hot read request, bit i to PE i
//   fifo_valid  : per-PE returned-data valid
//   fifo_r_data : per-PE word {addr, data}, slice i from PE i
//   m_we/m_addr/m_data/m_ready : master write with backpressure
// Modport master is the collector side; slave is the PE/master environment side.
interface mini16_s2m_collector_if #(
  parameter int unsigned NUM_PE    = 8,
  parameter int unsigned WIDTH_D   = 16,
  parameter int unsigned DEPTH_V_F = 16
);
  logic [NUM_PE-1:0]                      fifo_req_r;
  logic [NUM_PE-1:0]                      fifo_valid;
  logic [NUM_PE*(WIDTH_D+DEPTH_V_F)-1:0] fifo_r_data;
  logic                                   m_we;
  logic [DEPTH_V_F-1:0]                   m_addr;
  logic [WIDTH_D-1:0]                     m_data;
  logic                                   m_ready;

  modport master (
    output fifo_req_r,
    input  fifo_valid,
    input  fifo_r_data,
    output m_we,
    output m_addr,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_req_r,
    output fifo_valid,
    output fifo_r_data,
    input  m_we,
    input  m_addr,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/mini16_rr_pointer.sv
// Modulo-NUM_PE round-robin index counter.
//   i_clk     : clock
//   i_reset   : synchronous active-low reset, index returns to 0
//   i_advance : step to the next index, wrapping NUM_PE-1 -> 0
//   o_idx     : current index
module mini16_rr_pointer #(
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned WIDTH_PE = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_advance,
  output logic [WIDTH_PE-1:0] o_idx
);
  localparam logic [WIDTH_PE-1:0] Last = WIDTH_PE'(NUM_PE - 1);

  logic [WIDTH_PE-1:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_idx <= '0;
    end else if (i_advance) begin
      r_idx <= (r_idx == Last) ? '0 : r_idx + 1'b1;
    end
  end

  assign o_idx = r_idx;
endmodule

// File: rtl/mini16_s2m_collector.sv
// Drains the slave-to-master FIFOs of NUM_PE mini16 PEs round-robin and forwards each popped
// {addr, data} word as one write on the master bus.
//   i_clk          : clock
//   i_reset        : synchronous active-low reset
//   i_enable       : polling enable, gates only the start of a new poll
//   io_bus         : FIFO request/return and master write signals (master modport)
//   o_cur_pe       : PE currently selected
//   o_err_spurious : sticky flag for a valid that was not asked for
module mini16_s2m_collector
  import mini16_s2m_pkg::*;
#(
  parameter int unsigned NUM_PE       = 8,
  parameter int unsigned WIDTH_D      = 16,
  parameter int unsigned DEPTH_V_F    = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WIDTH_PE     = clog2_min1(NUM_PE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  mini16_s2m_collector_if.master io_bus,
  output logic [WIDTH_PE-1:0]   o_cur_pe,
  output logic                  o_err_spurious
);
  localparam int unsigned WordW = WIDTH_D + DEPTH_V_F;
  localparam int unsigned CntW  = 4;
  // The wait counter is 0 in the first WAIT cycle, so this value marks cycle READ_LATENCY.
  localparam logic [CntW-1:0] LatLast = CntW'(READ_LATENCY - 1);

  state_e               r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic                 r_we, w_we_next;
  logic [DEPTH_V_F-1:0] r_addr, w_addr_next;
  logic [WIDTH_D-1:0]   r_data, w_data_next;
  logic                 r_err, w_err_next;

  logic                 w_advance;
  logic [WIDTH_PE-1:0]  w_cur_pe;
  logic [NUM_PE-1:0]    w_sel;
  logic [NUM_PE-1:0]    w_legal;
  logic [WordW-1:0]     w_word;
  logic                 w_cur_valid;

  mini16_rr_pointer #(
    .NUM_PE   (NUM_PE),
    .WIDTH_PE (WIDTH_PE)
  ) u_ptr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_advance (w_advance),
    .o_idx     (w_cur_pe)
  );

  assign w_sel       = NUM_PE'(1) << w_cur_pe;
  assign w_word      = io_bus.fifo_r_data[w_cur_pe*WordW +: WordW];
  assign w_cur_valid = |(io_bus.fifo_valid & w_sel);

  // Only the selected PE may answer, and only while we are waiting for it.
  assign w_legal    = (r_state == StWait) ? w_sel : '0;
  assign w_err_next = r_err | (|(io_bus.fifo_valid & ~w_legal));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_we_next    = r_we;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_advance    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable) w_state_next = StReq;
      end
      StReq: begin
        w_cnt_next   = '0;
        w_state_next = StWait;
      end
      StWait: begin
        w_cnt_next = r_cnt + 1'b1;
        // A valid on the last allowed cycle still counts as data.
        if (w_cur_valid) begin
          w_addr_next  = DEPTH_V_F'(word_addr(MaxWordW'(w_word), WIDTH_D));
          w_data_next  = WIDTH_D'(word_data(MaxWordW'(w_word), WIDTH_D));
          w_we_next    = 1'b1;
          w_state_next = StWrite;
        end else if (r_cnt == LatLast) begin
          w_advance    = 1'b1;
          w_state_next = StIdle;
        end
      end
      StWrite: begin
        if (io_bus.m_ready) begin
          w_we_next    = 1'b0;
          w_advance    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_we    <= w_we_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
    end
  end

  assign io_bus.fifo_req_r = (r_state == StReq) ? w_sel : '0;
  assign io_bus.m_we       = r_we;
  assign io_bus.m_addr     = r_addr;
  assign io_bus.m_data     = r_data;
  assign o_cur_pe          = w_cur_pe;
  assign o_err_spurious    = r_err;
endmodule

// File: tb/tb_mini16_s2m_collector.sv
// Self-checking bench for mini16_s2m_collector: 4 PEs, READ_LATENCY=2.
// PE FIFOs are modelled as word queues answering a request after a per-PE delay;
// expected master writes are queued at setup and checked by a monitor on acceptance.
module tb_mini16_s2m_collector;
  import mini16_s2m_pkg::*;

  localparam int unsigned NPE = 4;
  localparam int unsigned WD  = 16;
  localparam int unsigned WA  = 16;
  localparam int unsigned RL  = 2;
  localparam int unsigned WPE = 2;
  localparam int unsigned WW  = WD + WA;

  typedef struct {
    int          pe;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [WPE-1:0] cur_pe;
  logic           err;
  logic [NPE-1:0] inj = '0;

  int   n_checks = 0;
  int   n_pass = 0;
  int   n_writes = 0;
  int   cyc = 0;
  int   last_wr = -1;
  bit   spacing_on = 1'b0;
  int   req_cnt[NPE];
  int   pe_delay[NPE];
  int   pe_cnt[NPE];
  logic [WW-1:0] pe_mem[NPE][$];
  exp_t exp_q[$];

  mini16_s2m_collector_if #(.NUM_PE(NPE), .WIDTH_D(WD), .DEPTH_V_F(WA)) bus ();

  mini16_s2m_collector #(
    .NUM_PE       (NPE),
    .WIDTH_D      (WD),
    .DEPTH_V_F    (WA),
    .READ_LATENCY (RL),
    .WIDTH_PE     (WPE)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_enable       (enable),
    .io_bus         (bus.master),
    .o_cur_pe       (cur_pe),
    .o_err_spurious (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // PE FIFO model: answer a request with valid + word after pe_delay cycles.
  always @(negedge clk) begin
    logic [NPE-1:0]    v;
    logic [NPE*WW-1:0] d;
    v = inj;
    d = '0;
    for (int i = 0; i < NPE; i++) begin
      if (pe_cnt[i] > 0) begin
        pe_cnt[i]--;
        if (pe_cnt[i] == 0 && pe_mem[i].size() > 0) begin
          v[i] = 1'b1;
          d[i*WW +: WW] = pe_mem[i].pop_front();
        end
      end
    end
    for (int i = 0; i < NPE; i++) begin
      if (bus.fifo_req_r[i] && pe_mem[i].size() > 0) pe_cnt[i] = pe_delay[i];
    end
    bus.fifo_valid  = v;
    bus.fifo_r_data = d;
  end

  // Monitor: request shape and scoreboard of accepted writes.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NPE; i++) if (bus.fifo_req_r[i]) req_cnt[i]++;
    if (bus.fifo_req_r != '0) check("req_onehot", 64'($countones(bus.fifo_req_r)), 64'd1);
    if (!spacing_on) last_wr = -1;
    if (bus.m_we && bus.m_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                 bus.m_addr, bus.m_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_pe", 64'(cur_pe), 64'(e.pe));
        check("wr_addr", 64'(bus.m_addr), 64'(e.addr));
        check("wr_data", 64'(bus.m_data), 64'(e.data));
        if (spacing_on && last_wr >= 0) check("wr_spacing", 64'(cyc - last_wr), 64'd4);
      end
      last_wr = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int pe, input logic [15:0] a, input logic [15:0] d, input bit exp);
    exp_t e;
    pe_mem[pe].push_back({a, d});
    if (exp) begin
      e.pe = pe; e.addr = a; e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_writes(input int n, input string name);
    int k = 0;
    while (n_writes < n && k < 300) begin tick(); k++; end
    check(name, 64'(n_writes >= n), 64'd1);
  endtask

  task automatic wait_pe(input int p, input string name);
    int k = 0;
    while (32'(cur_pe) != p && k < 300) begin tick(); k++; end
    check(name, 64'(cur_pe), 64'(p));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, 64'(bus.fifo_req_r), 64'd0);
    check({tag, "_we"}, 64'(bus.m_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.m_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.m_data), 64'd0);
    check({tag, "_cur_pe"}, 64'(cur_pe), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int k;
    logic seen;
    bus.m_ready = 1'b1;
    for (int i = 0; i < NPE; i++) pe_delay[i] = 1;
    repeat (3) tick();
    check_reset_vals("rst0");
    rst_n = 1'b1;
    tick();

    // Only PE2 holds a word; the others time out and the pointer wraps 3 -> 0.
    load(2, 16'h0123, 16'hBEEF, 1'b1);
    enable = 1'b1;
    wait_writes(1, "t1_write");
    wait_pe(0, "t1_wrap");
    enable = 1'b0;
    tick();
    for (int i = 0; i < NPE; i++) check($sformatf("t1_req_pe%0d", i), 64'(req_cnt[i]), 64'd1);

    // Two words per PE, valid one cycle after request: back-to-back every 4 cycles.
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < NPE; p++)
        load(p, 16'(16'h1000 + 16 * p + w), 16'(16'hA000 + 16 * p + w), 1'b1);
    spacing_on = 1'b1;
    enable = 1'b1;
    wait_writes(9, "t2_writes");
    spacing_on = 1'b0;
    enable = 1'b0;
    tick();

    // Backpressure: 10 cycles of m_ready low must hold the write and stop polling.
    load(0, 16'h0AAA, 16'h5555, 1'b1);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    k = 0;
    while (!bus.m_we && k < 50) begin tick(); k++; end
    check("t3_we_up", 64'(bus.m_we), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold", {27'd0, bus.m_we, bus.m_addr, bus.m_data, bus.fifo_req_r},
            {27'd0, 1'b1, 16'h0AAA, 16'h5555, 4'h0});
      tick();
    end
    bus.m_ready = 1'b1;
    enable = 1'b0;
    wait_writes(10, "t3_write");
    tick();
    check("t3_we_low", 64'(bus.m_we), 64'd0);
    check("t3_keep", {32'd0, bus.m_addr, bus.m_data}, {32'd0, 16'h0AAA, 16'h5555});
    check("t3_cur_pe", 64'(cur_pe), 64'd1);

    // Valid exactly at READ_LATENCY is data; one cycle later it is spurious.
    check("t4_err_clear", 64'(err), 64'd0);
    pe_delay[1] = RL;
    pe_delay[2] = RL + 1;
    load(1, 16'h1111, 16'h2222, 1'b1);
    load(2, 16'h3333, 16'h4444, 1'b0);
    enable = 1'b1;
    wait_writes(11, "t4_write");
    wait_pe(3, "t4_pe3");
    enable = 1'b0;
    repeat (2) tick();
    check("t4_late_err", 64'(err), 64'd1);
    check("t4_late_ignored", 64'(bus.m_addr), 64'h1111);
    for (int i = 0; i < NPE; i++) pe_delay[i] = 1;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("rst1");

    // Valid from PE1 while PE3 is selected sets the sticky error and writes nothing.
    enable = 1'b1;
    wait_pe(3, "t5_pe3");
    enable = 1'b0;
    inj = 4'b0010;
    tick();
    inj = '0;
    tick();
    check("t5_err", 64'(err), 64'd1);
    repeat (3) tick();
    check("t5_err_sticky", 64'(err), 64'd1);
    check("t5_no_we", 64'(bus.m_we), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_err_reset", 64'(err), 64'd0);
    check("t5_pe_reset", 64'(cur_pe), 64'd0);

    // Enable dropped one cycle after the request: the word still goes out, then park.
    load(0, 16'h0ABC, 16'h0DEF, 1'b1);
    enable = 1'b1;
    k = 0;
    while (bus.fifo_req_r == '0 && k < 50) begin tick(); k++; end
    check("t6_req", 64'(bus.fifo_req_r), 64'h1);
    tick();
    enable = 1'b0;
    wait_writes(12, "t6_write");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.fifo_req_r != '0) seen = 1'b1;
      tick();
    end
    check("t6_parked", 64'(seen), 64'd0);
    check("t6_cur_pe", 64'(cur_pe), 64'd1);
    load(1, 16'h0001, 16'h0002, 1'b1);
    enable = 1'b1;
    wait_writes(13, "t6_resume");
    enable = 1'b0;
    repeat (4) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("final_err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
